// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted-write FIFO from the MEM stage draining as single-beat AXI3 writes
// Optional feature macro: AXI_WB_KSEG_MAP_EN (strip kseg0/kseg1 segment bits from awaddr)
// Ports:
//   clk_i, reset_ni                 clock, asynchronous active-low reset
//   we_i/address_i/data_i/select_i  store request; mem_write_done_o acks it the same cycle
//   query_addr_i -> query_hit_o     read-after-write hazard lookup over all pending entries
//   wb_empty_o, wb_full_o           buffer status (empty also requires nothing in flight)
//   aw*_o/awready_i, w*_o/wready_i  AXI3 write address / data channels
//   bid_i/bresp_i/bvalid_i/bready_o AXI3 write response channel (id and resp ignored)
module axi_write_buffer #(
    parameter int DEPTH = 4,
    parameter logic [3:0] AXI_ID = 4'b0001,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        we_i,
    input  logic [31:0] address_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  select_i,
    output logic        mem_write_done_o,
    input  logic [31:0] query_addr_i,
    output logic        query_hit_o,
    output logic        wb_empty_o,
    output logic        wb_full_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic [1:0]  awlock_o,
    output logic [3:0]  awcache_o,
    output logic [2:0]  awprot_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, RESP = 2'd2;
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [3:0] sel_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0] count_q, count_d;
    logic [1:0] state_q, state_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic push, pop;
    logic [31:0] head;
    logic unused;
    assign unused = ^{bid_i, bresp_i, query_addr_i[1:0]};
    assign push = we_i & ~wb_full_o;
    assign pop = (state_q == RESP) & bvalid_i;
    assign head = addr_q[rd_q];
    always_comb begin
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        wr_d = wr_q + PTR_W'(push);
        rd_d = rd_q + PTR_W'(pop);
        state_d = state_q;
        awvalid_d = awvalid_q;
        wvalid_d = wvalid_q;
        if (state_q == IDLE && count_q != '0) begin
            state_d = SEND;
            awvalid_d = 1'b1;
            wvalid_d = 1'b1;
        end
        if (state_q == SEND) begin
            awvalid_d = awvalid_q & ~awready_i;
            wvalid_d = wvalid_q & ~wready_i;
            state_d = (awvalid_d | wvalid_d) ? SEND : RESP;
        end
        // Count after the pop includes a same-cycle push, so a new entry chains straight into SEND.
        if (pop) begin
            state_d = (count_d != '0) ? SEND : IDLE;
            awvalid_d = count_d != '0;
            wvalid_d = count_d != '0;
        end
    end
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_q <= '0;
            wr_q <= '0;
            count_q <= '0;
            state_q <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            count_q <= count_d;
            state_q <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q <= wvalid_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[wr_q] <= address_i;
            data_q[wr_q] <= data_i;
            sel_q[wr_q] <= select_i;
        end
    end
    // An entry is live when its distance from the head (mod DEPTH) is below count.
    always_comb begin
        query_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, PTR_W'(PTR_W'(i) - rd_q)} < count_q && addr_q[i][31:2] == query_addr_i[31:2])
                query_hit_o = 1'b1;
    end
`ifdef AXI_WB_KSEG_MAP_EN
    assign awaddr_o = (head[31:30] == 2'b10) ? {3'b000, head[28:0]} : head;
`else
    assign awaddr_o = head;
`endif
    assign mem_write_done_o = push;
    assign wb_full_o = count_q == (PTR_W+1)'(DEPTH);
    assign wb_empty_o = count_q == '0 && state_q == IDLE;
    assign awid_o = AXI_ID;
    assign awlen_o = 4'd0;
    assign awsize_o = 3'b010;
    assign awburst_o = 2'b01;
    assign awlock_o = 2'b00;
    assign awcache_o = 4'd0;
    assign awprot_o = 3'd0;
    assign awvalid_o = awvalid_q;
    assign wid_o = AXI_ID;
    assign wdata_o = data_q[rd_q];
    assign wstrb_o = sel_q[rd_q];
    assign wlast_o = 1'b1;
    assign wvalid_o = wvalid_q;
    assign bready_o = 1'b1;
endmodule
